// File: rtl/i2c_memory_writer_controller_if.sv
// Control stream and two-wire bus signals shared by the I2C memory-writer controller and its environment.
// The master modport is the controller's view; the slave modport is the data source / bus side.
interface i2c_memory_writer_controller_if #(
   parameter int unsigned COUNT_WIDTH = 8
);
   logic                   start;
   logic                   ebr_select;
   logic [COUNT_WIDTH-1:0] byte_count;
   logic [7:0]             data_in;
   logic                   data_valid;
   logic                   data_ready;
   logic                   copi_scl;
   logic                   copi_sda;
   logic                   cipo_sda;
   logic                   busy;
   logic                   done;
   logic                   nack_error;

   modport master (
      input  start, ebr_select, byte_count, data_in, data_valid, cipo_sda,
      output data_ready, copi_scl, copi_sda, busy, done, nack_error
   );

   modport slave (
      output start, ebr_select, byte_count, data_in, data_valid, cipo_sda,
      input  data_ready, copi_scl, copi_sda, busy, done, nack_error
   );
endinterface

// File: rtl/i2c_memory_writer_controller.sv
// I2C initiator that writes one frame: START, device address, EBR select, byte_count streamed data bytes, STOP.
// Every bus phase is split into four quarters of CLOCK_DIVIDE clocks; outputs change on entry to a quarter.
module i2c_memory_writer_controller #(
   parameter int unsigned CLOCK_DIVIDE   = 4,
   parameter logic [7:0]  DEVICE_ADDRESS = 8'hFE,
   parameter int unsigned COUNT_WIDTH    = 8
) (
   input  logic                              clock,
   input  logic                              reset,
   i2c_memory_writer_controller_if.master    bus
);

   localparam int unsigned DIV_WIDTH = $clog2(CLOCK_DIVIDE);
   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLOCK_DIVIDE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      SHIFT,
      ACK,
      WAIT_DATA,
      STOP
   } state_t;

   typedef enum logic [1:0] {
      BYTE_ADDR,
      BYTE_SELECT,
      BYTE_DATA
   } byte_kind_t;

   state_t                 state;
   byte_kind_t             byte_kind;
   logic [DIV_WIDTH-1:0]   divider;
   logic [1:0]             quarter;
   logic                   setup_quarter;
   logic [2:0]             bit_index;
   logic [7:0]             shift;
   logic                   ebr_select_q;
   logic [COUNT_WIDTH-1:0] remaining;
   logic                   nack_flag;
   logic                   scl;
   logic                   sda;
   logic                   busy;
   logic                   done;
   logic                   nack_error;
   logic                   tick;
   logic [7:0]             select_byte;

   // The divider only runs while the bus is being clocked; a data stall freezes SCL low.
   assign tick        = (state != IDLE) && (state != WAIT_DATA) && (divider == DIV_LAST);
   assign select_byte = {7'b0, ebr_select_q};

   assign bus.copi_scl   = scl;
   assign bus.copi_sda   = sda;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.nack_error = nack_error;
   assign bus.data_ready = (state == WAIT_DATA) && bus.data_valid;

   // NOTE: every register here is written with <= so all branches see pre-edge values of each other.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         byte_kind     <= BYTE_ADDR;
         divider       <= '0;
         quarter       <= '0;
         setup_quarter <= 1'b0;
         bit_index     <= 3'd7;
         shift         <= '0;
         ebr_select_q  <= 1'b0;
         remaining     <= '0;
         nack_flag     <= 1'b0;
         scl           <= 1'b1;
         sda           <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         nack_error    <= 1'b0;
      end else begin
         done       <= 1'b0;
         nack_error <= 1'b0;

         if (state == IDLE || state == WAIT_DATA || tick) begin
            divider <= '0;
         end else begin
            divider <= divider + DIV_WIDTH'(1);
         end

         case (state)
            IDLE: begin
               if (bus.start) begin
                  ebr_select_q  <= bus.ebr_select;
                  remaining     <= bus.byte_count;
                  busy          <= 1'b1;
                  shift         <= DEVICE_ADDRESS;
                  byte_kind     <= BYTE_ADDR;
                  nack_flag     <= 1'b0;
                  quarter       <= 2'd0;
                  setup_quarter <= 1'b1;
                  state         <= START;
               end
            end

            // A released-bus setup quarter precedes the START quarters so SDA falls well inside SCL high.
            START: begin
               if (tick) begin
                  if (setup_quarter) begin
                     setup_quarter <= 1'b0;
                     sda           <= 1'b0;
                  end else begin
                     quarter <= quarter + 2'd1;
                     case (quarter)
                        2'd1: scl <= 1'b0;
                        2'd3: begin
                           state     <= SHIFT;
                           bit_index <= 3'd7;
                           sda       <= shift[7];
                        end
                        default: ;
                     endcase
                  end
               end
            end

            SHIFT: begin
               if (tick) begin
                  quarter <= quarter + 2'd1;
                  case (quarter)
                     2'd0: scl <= 1'b1;
                     2'd2: begin
                        scl   <= 1'b0;
                        shift <= {shift[6:0], 1'b0};
                     end
                     2'd3: begin
                        if (bit_index == 3'd0) begin
                           state <= ACK;
                           sda   <= 1'b1;
                        end else begin
                           bit_index <= bit_index - 3'd1;
                           sda       <= shift[7];
                        end
                     end
                     default: ;
                  endcase
               end
            end

            ACK: begin
               if (tick) begin
                  quarter <= quarter + 2'd1;
                  case (quarter)
                     2'd0: scl <= 1'b1;
                     2'd2: begin
                        scl <= 1'b0;
                        if (bus.cipo_sda) begin
                           nack_flag <= 1'b1;
                        end
                     end
                     2'd3: begin
                        if (nack_flag) begin
                           state <= STOP;
                           sda   <= 1'b0;
                        end else if (byte_kind == BYTE_ADDR) begin
                           byte_kind <= BYTE_SELECT;
                           shift     <= select_byte;
                           bit_index <= 3'd7;
                           sda       <= select_byte[7];
                           state     <= SHIFT;
                        end else if (remaining != '0) begin
                           state <= WAIT_DATA;
                        end else begin
                           state <= STOP;
                           sda   <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end

            WAIT_DATA: begin
               if (bus.data_valid) begin
                  shift     <= bus.data_in;
                  remaining <= remaining - COUNT_WIDTH'(1);
                  byte_kind <= BYTE_DATA;
                  bit_index <= 3'd7;
                  sda       <= bus.data_in[7];
                  state     <= SHIFT;
               end
            end

            // SCL rises a quarter before SDA so the rising SDA edge is a STOP condition.
            STOP: begin
               if (tick) begin
                  quarter <= quarter + 2'd1;
                  case (quarter)
                     2'd0: scl <= 1'b1;
                     2'd1: sda <= 1'b1;
                     2'd3: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        nack_error <= nack_flag;
                        nack_flag  <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_memory_writer_controller.sv
// Directed bench for the I2C memory-writer controller with a behavioural write peripheral on a wired-AND SDA.
module tb_i2c_memory_writer_controller;

   localparam int CD          = 4;
   localparam int FRAME_ZERO  = (5 + 36 * 2 + 4) * CD;
   localparam int FRAME_NACK  = (5 + 36 + 4) * CD;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   i2c_memory_writer_controller_if #(.COUNT_WIDTH(8)) bus ();

   i2c_memory_writer_controller #(
      .CLOCK_DIVIDE  (CD),
      .DEVICE_ADDRESS(8'hFE),
      .COUNT_WIDTH   (8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Event counters observed at the rising edge.
   int   done_count  = 0;
   int   ready_count = 0;
   int   stop_count  = 0;
   logic last_nack   = 1'b0;

   always @(posedge clock) begin
      if (bus.done === 1'b1) begin
         done_count <= done_count + 1;
         last_nack  <= bus.nack_error;
      end
      if (bus.data_ready === 1'b1) ready_count <= ready_count + 1;
   end

   // Data source: presents src_data[n] for the n-th byte consumed since src_base.
   logic       src_en = 1'b0;
   logic [7:0] src_data [8];
   int         src_base = 0;

   always @(negedge clock) begin
      bus.data_valid = src_en;
      bus.data_in    = src_data[(ready_count - src_base) & 7];
   end

   // Behavioural write peripheral.
   logic       p_cipo      = 1'b1;
   logic       p_scl_d     = 1'b1;
   logic       p_sda_d     = 1'b1;
   logic       p_active    = 1'b0;
   logic       p_in_ack    = 1'b0;
   logic       p_addressed = 1'b0;
   logic       p_sel       = 1'b0;
   logic [7:0] p_shreg     = 8'h00;
   logic [7:0] periph_addr = 8'hFE;
   int         p_bitcnt    = 0;
   int         p_byte_idx  = 0;
   logic [7:0] rx_q [$];
   logic [7:0] wr_q [$];
   logic       wr_sel_q [$];
   logic       sda_bus;

   assign bus.cipo_sda = p_cipo;
   assign sda_bus      = bus.copi_sda & p_cipo;

   always @(posedge clock) begin
      p_scl_d <= bus.copi_scl;
      p_sda_d <= sda_bus;
      if (p_scl_d && bus.copi_scl === 1'b1 && p_sda_d && sda_bus === 1'b0) begin
         p_active    <= 1'b1;
         p_in_ack    <= 1'b0;
         p_addressed <= 1'b0;
         p_bitcnt    <= 0;
         p_byte_idx  <= 0;
         p_cipo      <= 1'b1;
      end else if (p_scl_d && bus.copi_scl === 1'b1 && !p_sda_d && sda_bus === 1'b1) begin
         if (p_active) stop_count <= stop_count + 1;
         p_active <= 1'b0;
         p_in_ack <= 1'b0;
         p_cipo   <= 1'b1;
      end else if (p_active) begin
         if (!p_scl_d && bus.copi_scl === 1'b1 && !p_in_ack) begin
            p_shreg  <= {p_shreg[6:0], sda_bus};
            p_bitcnt <= p_bitcnt + 1;
         end else if (p_scl_d && bus.copi_scl === 1'b0) begin
            if (p_in_ack) begin
               p_in_ack <= 1'b0;
               p_cipo   <= 1'b1;
            end else if (p_bitcnt == 8) begin
               p_in_ack   <= 1'b1;
               p_bitcnt   <= 0;
               p_byte_idx <= p_byte_idx + 1;
               if ((p_byte_idx == 0) ? (p_shreg == periph_addr) : p_addressed) begin
                  p_cipo <= 1'b0;
                  rx_q.push_back(p_shreg);
                  if (p_byte_idx == 0) p_addressed <= 1'b1;
                  else if (p_byte_idx == 1) p_sel <= p_shreg[0];
                  else begin
                     wr_q.push_back(p_shreg);
                     wr_sel_q.push_back(p_sel);
                  end
               end
            end
         end
      end
   end

   task automatic launch(input logic sel, input logic [7:0] cnt);
      @(negedge clock);
      bus.ebr_select = sel;
      bus.byte_count = cnt;
      bus.start      = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cycles);
      cycles = 1;
      while (bus.done !== 1'b1 && cycles < limit) begin
         @(negedge clock);
         cycles++;
      end
      tests_run++;
      if (bus.done !== 1'b1) begin
         tests_failed++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, cycles);
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      src_en = 1'b0;
      repeat (3) @(negedge clock);
      tests_run++;
      if (bus.copi_scl !== 1'b1) begin tests_failed++; $display("FAIL reset_scl: got %b required 1", bus.copi_scl); end
      tests_run++;
      if (bus.copi_sda !== 1'b1) begin tests_failed++; $display("FAIL reset_sda: got %b required 1", bus.copi_sda); end
      tests_run++;
      if ({bus.busy, bus.done, bus.nack_error, bus.data_ready} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: busy/done/nack/ready got %b required 0000",
                  {bus.busy, bus.done, bus.nack_error, bus.data_ready});
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_two_bytes();
      int d0, r0, w0, s0, cyc;
      d0 = done_count; r0 = ready_count; w0 = wr_q.size(); s0 = stop_count;
      src_data[0] = 8'hA5; src_data[1] = 8'h3C; src_base = ready_count; src_en = 1'b1;
      @(negedge clock);
      launch(1'b1, 8'd2);
      tests_run++;
      if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL two_busy: got %b required 1", bus.busy); end
      wait_done(2000, cyc);
      tests_run++;
      if (bus.nack_error !== 1'b0) begin tests_failed++; $display("FAIL two_nack: got %b required 0", bus.nack_error); end
      repeat (4) @(negedge clock);
      src_en = 1'b0;
      tests_run++;
      if (done_count - d0 != 1) begin tests_failed++; $display("FAIL two_done_count: got %0d required 1", done_count - d0); end
      tests_run++;
      if (ready_count - r0 != 2) begin tests_failed++; $display("FAIL two_ready_count: got %0d required 2", ready_count - r0); end
      tests_run++;
      if (wr_q.size() - w0 != 2) begin
         tests_failed++; $display("FAIL two_write_count: got %0d required 2", wr_q.size() - w0);
      end else begin
         tests_run++;
         if (wr_q[w0] !== 8'hA5 || wr_q[w0+1] !== 8'h3C) begin
            tests_failed++; $display("FAIL two_write_data: got %h %h required a5 3c", wr_q[w0], wr_q[w0+1]);
         end
         tests_run++;
         if (wr_sel_q[w0] !== 1'b1 || wr_sel_q[w0+1] !== 1'b1) begin
            tests_failed++; $display("FAIL two_write_sel: got %b %b required 1 1", wr_sel_q[w0], wr_sel_q[w0+1]);
         end
      end
      tests_run++;
      if (stop_count - s0 != 1) begin tests_failed++; $display("FAIL two_stop: got %0d required 1", stop_count - s0); end
      tests_run++;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL two_busy_end: got %b required 0", bus.busy); end
   endtask

   task automatic test_nack();
      int d0, r0, w0, s0, cyc;
      d0 = done_count; r0 = ready_count; w0 = wr_q.size(); s0 = stop_count;
      periph_addr = 8'hA0;
      src_data[0] = 8'h11; src_base = ready_count; src_en = 1'b1;
      @(negedge clock);
      launch(1'b1, 8'd3);
      wait_done(2000, cyc);
      tests_run++;
      if (bus.nack_error !== 1'b1) begin tests_failed++; $display("FAIL nack_with_done: got %b required 1", bus.nack_error); end
      tests_run++;
      if (cyc < FRAME_NACK - 1 || cyc > FRAME_NACK + 1) begin
         tests_failed++; $display("FAIL nack_length: got %0d clocks required %0d", cyc, FRAME_NACK);
      end
      repeat (4) @(negedge clock);
      src_en = 1'b0;
      periph_addr = 8'hFE;
      tests_run++;
      if (done_count - d0 != 1 || last_nack !== 1'b1) begin
         tests_failed++; $display("FAIL nack_done: count %0d nack %b required 1 1", done_count - d0, last_nack);
      end
      tests_run++;
      if (ready_count - r0 != 0 || wr_q.size() - w0 != 0) begin
         tests_failed++; $display("FAIL nack_no_data: ready %0d writes %0d required 0 0", ready_count - r0, wr_q.size() - w0);
      end
      tests_run++;
      if (p_active !== 1'b0 || stop_count - s0 != 1) begin
         tests_failed++; $display("FAIL nack_periph_idle: active %b stops %0d required 0 1", p_active, stop_count - s0);
      end
   endtask

   task automatic test_zero_bytes();
      int r0, q0, cyc;
      r0 = ready_count; q0 = rx_q.size();
      launch(1'b0, 8'd0);
      wait_done(2000, cyc);
      tests_run++;
      if (cyc < FRAME_ZERO - 1 || cyc > FRAME_ZERO + 1) begin
         tests_failed++; $display("FAIL zero_length: got %0d clocks required %0d", cyc, FRAME_ZERO);
      end
      repeat (4) @(negedge clock);
      tests_run++;
      if (rx_q.size() - q0 != 2) begin
         tests_failed++; $display("FAIL zero_rx_count: got %0d required 2", rx_q.size() - q0);
      end else begin
         tests_run++;
         if (rx_q[q0] !== 8'hFE || rx_q[q0+1] !== 8'h00) begin
            tests_failed++; $display("FAIL zero_rx_bytes: got %h %h required fe 00", rx_q[q0], rx_q[q0+1]);
         end
      end
      tests_run++;
      if (ready_count - r0 != 0 || last_nack !== 1'b0) begin
         tests_failed++; $display("FAIL zero_ready_nack: ready %0d nack %b required 0 0", ready_count - r0, last_nack);
      end
   endtask

   task automatic test_stall();
      int r0, w0, cyc, high;
      r0 = ready_count; w0 = wr_q.size(); high = 0;
      src_en = 1'b0; src_data[0] = 8'h5A; src_base = ready_count;
      @(negedge clock);
      launch(1'b1, 8'd1);
      repeat (309) @(negedge clock);
      for (int i = 0; i < 100; i++) begin
         if (bus.copi_scl !== 1'b0) high++;
         @(negedge clock);
      end
      tests_run++;
      if (high != 0) begin tests_failed++; $display("FAIL stall_scl: %0d high samples required 0", high); end
      tests_run++;
      if (wr_q.size() - w0 != 0 || ready_count - r0 != 0) begin
         tests_failed++; $display("FAIL stall_early_write: writes %0d ready %0d required 0 0", wr_q.size() - w0, ready_count - r0);
      end
      src_en = 1'b1;
      wait_done(1000, cyc);
      repeat (4) @(negedge clock);
      src_en = 1'b0;
      tests_run++;
      if (wr_q.size() - w0 != 1 || ready_count - r0 != 1) begin
         tests_failed++; $display("FAIL stall_write_count: writes %0d ready %0d required 1 1", wr_q.size() - w0, ready_count - r0);
      end else begin
         tests_run++;
         if (wr_q[w0] !== 8'h5A || last_nack !== 1'b0) begin
            tests_failed++; $display("FAIL stall_write_data: got %h nack %b required 5a 0", wr_q[w0], last_nack);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int d0, s0, w0, cyc;
      d0 = done_count; s0 = stop_count;
      src_data[0] = 8'hC3; src_base = ready_count; src_en = 1'b1;
      @(negedge clock);
      launch(1'b1, 8'd1);
      repeat (233) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      tests_run++;
      if ({bus.copi_scl, bus.copi_sda, bus.busy, bus.done} !== 4'b1100) begin
         tests_failed++; $display("FAIL midreset_outputs: scl/sda/busy/done got %b required 1100",
                                  {bus.copi_scl, bus.copi_sda, bus.busy, bus.done});
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      tests_run++;
      if (done_count - d0 != 0) begin tests_failed++; $display("FAIL midreset_done: got %0d required 0", done_count - d0); end
      tests_run++;
      if (p_active !== 1'b0 || stop_count - s0 != 1) begin
         tests_failed++; $display("FAIL midreset_stop: active %b stops %0d required 0 1", p_active, stop_count - s0);
      end
      w0 = wr_q.size();
      src_data[0] = 8'h77; src_base = ready_count;
      @(negedge clock);
      launch(1'b0, 8'd1);
      wait_done(2000, cyc);
      repeat (4) @(negedge clock);
      src_en = 1'b0;
      tests_run++;
      if (wr_q.size() - w0 != 1) begin
         tests_failed++; $display("FAIL midreset_restart_count: got %0d required 1", wr_q.size() - w0);
      end else begin
         tests_run++;
         if (wr_q[w0] !== 8'h77 || wr_sel_q[w0] !== 1'b0 || last_nack !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_restart_data: got %h sel %b nack %b required 77 0 0",
                                     wr_q[w0], wr_sel_q[w0], last_nack);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int d0, q0, cyc;
      d0 = done_count; q0 = rx_q.size();
      launch(1'b0, 8'd0);
      repeat (8) @(negedge clock);
      bus.ebr_select = 1'b1;
      bus.byte_count = 8'd5;
      bus.start      = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      wait_done(2000, cyc);
      cyc = cyc + 9;
      tests_run++;
      if (cyc < FRAME_ZERO - 1 || cyc > FRAME_ZERO + 1) begin
         tests_failed++; $display("FAIL busy_start_length: got %0d clocks required %0d", cyc, FRAME_ZERO);
      end
      repeat (400) @(negedge clock);
      tests_run++;
      if (done_count - d0 != 1 || bus.busy !== 1'b0) begin
         tests_failed++; $display("FAIL busy_start_done: count %0d busy %b required 1 0", done_count - d0, bus.busy);
      end
      tests_run++;
      if (rx_q.size() - q0 != 2 || rx_q[q0+1] !== 8'h00) begin
         tests_failed++; $display("FAIL busy_start_select: rx %0d select %h required 2 00", rx_q.size() - q0, rx_q[q0+1]);
      end
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.ebr_select = 1'b0;
      bus.byte_count = 8'd0;
      for (int i = 0; i < 8; i++) src_data[i] = 8'h00;
      test_reset();
      test_two_bytes();
      test_nack();
      test_zero_bytes();
      test_stall();
      test_reset_mid_frame();
      test_start_while_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
